// File: rtl/axis_compress_a1_if.sv
// AXI4-Stream bundle shared by the compressor's address input and record output.
// The slave view carries only the fields the compressor consumes.
interface axis_compress_a1_if #(
    parameter int DW = 8,
    parameter int KW = 1
);
    logic [DW-1:0] tdata;
    logic          tvalid;
    logic          tready;
    logic          tlast;
    logic          tuser;
    logic [KW-1:0] tkeep;

    modport master (output tdata, tvalid, tlast, tuser, tkeep, input tready);
    modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_compress_a1.sv
// Run-length compressor: folds each run of addresses advancing by STEP into one
// {start_addr, len} record, where len = run_count - 1.
module axis_compress_a1 #(
    parameter int               ASIZE = 8,
    parameter int               LSIZE = 8,
    parameter logic [ASIZE-1:0] STEP  = 1
) (
    input  logic clock,
    input  logic rst_n,
    input  logic clken,
    axis_compress_a1_if.slave  s,
    axis_compress_a1_if.master m
);
    localparam int OW = ASIZE + LSIZE;

    typedef enum logic [1:0] {EMPTY, OPEN, CLOSED} state_t;

    state_t           state_q, state_d;
    logic [ASIZE-1:0] start_q, start_d;
    logic [ASIZE-1:0] prev_q, prev_d;
    logic [LSIZE-1:0] len_q, len_d;
    logic [LSIZE-1:0] len_inc;
    logic [ASIZE-1:0] next_addr;

    logic [OW-1:0]    m_data_q;
    logic             m_valid_q;
    logic             m_last_q;

    logic             out_free;
    logic             s_ready;
    logic             accept;
    logic             contig;
    logic             push;
    logic [OW-1:0]    push_data;
    logic             push_last;

    assign out_free  = !m_valid_q || m.tready;
    assign s_ready   = clken && (state_q != CLOSED) && out_free;
    assign accept    = s.tvalid && s_ready;
    assign next_addr = prev_q + STEP;
    assign len_inc   = len_q + 1'b1;
    // A saturated length field forces the next beat to open a new run.
    assign contig    = (s.tdata == next_addr) && (len_q != {LSIZE{1'b1}});

    // NOTE: every output of this block is defaulted first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        start_d   = start_q;
        prev_d    = prev_q;
        len_d     = len_q;
        push      = 1'b0;
        push_data = '0;
        push_last = 1'b0;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (s.tlast) begin
                        push      = 1'b1;
                        push_data = {s.tdata, {LSIZE{1'b0}}};
                        push_last = 1'b1;
                    end else begin
                        start_d = s.tdata;
                        prev_d  = s.tdata;
                        len_d   = '0;
                        state_d = OPEN;
                    end
                end
            end
            OPEN: begin
                if (accept) begin
                    if (contig) begin
                        len_d  = len_inc;
                        prev_d = s.tdata;
                        if (s.tlast) begin
                            push      = 1'b1;
                            push_data = {start_q, len_inc};
                            push_last = 1'b1;
                            state_d   = EMPTY;
                        end
                    end else begin
                        push      = 1'b1;
                        push_data = {start_q, len_q};
                        start_d   = s.tdata;
                        prev_d    = s.tdata;
                        len_d     = '0;
                        state_d   = s.tlast ? CLOSED : OPEN;
                    end
                end
            end
            CLOSED: begin
                // The last beat broke a run, so its single-address record
                // still has to go out before new input is taken.
                if (clken && out_free) begin
                    push      = 1'b1;
                    push_data = {start_q, {LSIZE{1'b0}}};
                    push_last = 1'b1;
                    state_d   = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    // NOTE: all registers here are reset; none are memories, and the reset
    // values define the idle output (record invalid, data zero).
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            start_q <= '0;
            prev_q  <= '0;
            len_q   <= '0;
        end else if (clken) begin
            state_q <= state_d;
            start_q <= start_d;
            prev_q  <= prev_d;
            len_q   <= len_d;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (push) begin
            m_data_q  <= push_data;
            m_valid_q <= 1'b1;
            m_last_q  <= push_last;
        end else if (m.tready && clken) begin
            m_valid_q <= 1'b0;
        end
    end

    assign s.tready = s_ready;
    assign m.tdata  = m_data_q;
    assign m.tvalid = m_valid_q;
    assign m.tlast  = m_last_q;
    assign m.tuser  = 1'b0;
    assign m.tkeep  = '1;
endmodule
